// File: rtl/snpu_pkg.sv
// Shared definitions for the random-number bank scheduler: bank geometry
// defaults and the scheduler FSM state encoding.
package snpu_pkg;

    localparam int SNPU_RND_N = 32;
    localparam int SNPU_W     = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FREEZE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last winner
// whenever advance is asserted.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned   idx;
            logic [PW-1:0] j;
            idx = 32'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            j = PW'(idx);
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                win    = j;
            end
        end
    end

    // ptr holds the index with top priority for the next search
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win == LAST) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/rnd_bank_scheduler.sv
// Arbitrates single-word requests onto a bank of free-running generators:
// freeze the bank, let it settle, capture the selected word, release and ack.
module rnd_bank_scheduler
    import snpu_pkg::*;
#(
    parameter int RND_N = SNPU_RND_N,
    parameter int W     = SNPU_W,
    parameter int NREQ  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [3:0]               settle_cycles,
    input  logic [W-1:0]             rand_in,
    output logic                     bank_freeze,
    output logic [$clog2(RND_N)-1:0] bank_addr,
    output logic [NREQ-1:0]          ack,
    output logic [W-1:0]             data,
    output logic                     stuck_err
);

    localparam int AW = $clog2(RND_N);
    localparam logic [AW-1:0] ADDR_LAST = AW'(RND_N - 1);

    logic [1:0]      state;
    logic [3:0]      settle_cnt;
    logic [NREQ-1:0] granted;
    logic [NREQ-1:0] gnt;
    logic            advance;
    logic [1:0]      rep_cnt;
    logic [1:0]      rep_nxt;
    logic [W-1:0]    prev_word;

    assign advance = (state == ST_IDLE) && (|req);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        rep_nxt = '0;
        if (rand_in == prev_word) begin
            rep_nxt = (rep_cnt == 2'd3) ? 2'd3 : rep_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            granted     <= '0;
            bank_freeze <= 1'b0;
            bank_addr   <= '0;
            ack         <= '0;
            data        <= '0;
            stuck_err   <= 1'b0;
            rep_cnt     <= '0;
            prev_word   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        granted     <= gnt;
                        settle_cnt  <= settle_cycles;
                        bank_freeze <= 1'b1;
                        state       <= ST_FREEZE;
                    end
                end
                ST_FREEZE: begin
                    if (settle_cnt == 4'd0) state <= ST_CAPTURE;
                    else settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CAPTURE: begin
                    data        <= rand_in;
                    prev_word   <= rand_in;
                    rep_cnt     <= rep_nxt;
                    stuck_err   <= stuck_err | (rep_nxt == 2'd3);
                    ack         <= granted;
                    bank_freeze <= 1'b0;
                    state       <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    ack       <= '0;
                    bank_addr <= (bank_addr == ADDR_LAST) ? '0 : bank_addr + 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
